// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing constants and colour field positions
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_VISIBLE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_VISIBLE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int COLOUR_W = 8;
    localparam int FG_MSB   = 15;
    localparam int FG_LSB   = 8;
    localparam int BG_MSB   = 7;
    localparam int BG_LSB   = 0;

endpackage

// File: rtl/vga_sig_gen.sv
// rtl/vga_sig_gen.sv - pixel enable, HC/VC counters, sync and visible decode
module vga_sig_gen
    import vga_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             visible,
    output logic             hs,
    output logic             vs
);

    logic             pe_q, pe_d;
    logic [CNT_W-1:0] hc_q, hc_d;
    logic [CNT_W-1:0] vc_q, vc_d;

    always_comb begin
        pe_d = ~pe_q;
        hc_d = hc_q;
        vc_d = vc_q;
        if (pe_q) begin
            if (hc_q == CNT_W'(H_TOTAL - 1)) begin
                hc_d = '0;
                vc_d = (vc_q == CNT_W'(V_TOTAL - 1)) ? '0 : vc_q + CNT_W'(1);
            end else begin
                hc_d = hc_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pe_q <= 1'b0;
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            pe_q <= pe_d;
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    // Decodes are combinational from the counters; the top registers them.
    always_comb begin
        hc      = hc_q;
        vc      = vc_q;
        visible = (hc_q < CNT_W'(H_VISIBLE)) && (vc_q < CNT_W'(V_VISIBLE));
        hs      = !((hc_q >= CNT_W'(H_SYNC_START)) && (hc_q <= CNT_W'(H_SYNC_END)));
        vs      = !((vc_q >= CNT_W'(V_SYNC_START)) && (vc_q <= CNT_W'(V_SYNC_END)));
    end

endmodule

// File: rtl/vga_wrapper.sv
// rtl/vga_wrapper.sv - VGA top: checkerboard colour mux and registered outputs
module vga_wrapper
    import vga_pkg::*;
#(
    parameter logic [15:0] CONFIG_COLOURS = 16'hAA00,
    parameter int          TILE_LOG2      = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    output logic [COLOUR_W-1:0] VGA_COLOUR,
    output logic                VGA_HS,
    output logic                VGA_VS
);

    logic [CNT_W-1:0]    hc;
    logic [CNT_W-1:0]    vc;
    logic                visible;
    logic                hs;
    logic                vs;

    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                hs_q, hs_d;
    logic                vs_q, vs_d;
    logic                pattern_bit;

    vga_sig_gen u_sig_gen (
        .clk     (CLK),
        .resetn  (RESET),
        .hc      (hc),
        .vc      (vc),
        .visible (visible),
        .hs      (hs),
        .vs      (vs)
    );

    always_comb begin
        pattern_bit = hc[TILE_LOG2] ^ vc[TILE_LOG2];
        colour_d    = '0;
        if (visible) begin
            colour_d = pattern_bit ? CONFIG_COLOURS[FG_MSB:FG_LSB]
                                   : CONFIG_COLOURS[BG_MSB:BG_LSB];
        end
        hs_d = hs;
        vs_d = vs;
    end

    // Outputs lag the counters by one CLK so all three stay aligned.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            colour_q <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
        end else begin
            colour_q <= colour_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
        end
    end

    assign VGA_COLOUR = colour_q;
    assign VGA_HS     = hs_q;
    assign VGA_VS     = vs_q;

endmodule

// File: tb/tb_vga_wrapper.sv
// tb/tb_vga_wrapper.sv - directed vector and timing bench for vga_wrapper
module tb_vga_wrapper;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] colour;
    logic       hs;
    logic       vs;

    always #5 clk = ~clk;

    vga_wrapper #(
        .CONFIG_COLOURS (16'hAA00),
        .TILE_LOG2      (4)
    ) dut (
        .CLK        (clk),
        .RESET      (resetn),
        .VGA_COLOUR (colour),
        .VGA_HS     (hs),
        .VGA_VS     (vs)
    );

    typedef struct {
        int         phase;
        int         cyc;
        logic [7:0] colour;
        logic       hs;
        logic       vs;
    } vec_t;

    vec_t       vecs[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         k;
    int         y_base;
    int         cur_phase;
    logic [9:0] force_vc;
    bit         forced = 1'b0;
    int         hs_fall[$];
    int         hs_rise[$];
    int         vs_fall[$];
    int         vs_rise[$];
    int         col_err;
    int         hs_err;
    int         vs_err;

    // Output cycle k (1 = first edge after release) shows pixel p = (k-1)/2;
    // the second CLK of pixel (x, line) is therefore k = 2*p + 2.
    function automatic int px(input int x, input int line);
        return 2 * (line * 800 + x) + 2;
    endfunction

    function automatic void add(input int ph, input int x, input int line,
                                input logic [7:0] c, input logic h, input logic v);
        vec_t e;
        e.phase  = ph;
        e.cyc    = px(x, line);
        e.colour = c;
        e.hs     = h;
        e.vs     = v;
        vecs.push_back(e);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int ncyc);
        resetn = 1'b0;
        repeat (ncyc) tick();
    endtask

    task automatic start(input int ph, input int y0);
        resetn    = 1'b1;
        k         = 0;
        cur_phase = ph;
        y_base    = y0;
        if (y0 != 0) begin
            force_vc = 10'(y0);
            force dut.u_sig_gen.vc_q = force_vc;
            forced = 1'b1;
        end
    endtask

    task automatic run(input int ncyc);
        logic       prev_hs;
        logic       prev_vs;
        int         p;
        int         x;
        int         y;
        bit         vis;
        logic [7:0] ec;
        logic       eh;
        logic       ev;
        prev_hs = hs;
        prev_vs = vs;
        col_err = 0;
        hs_err  = 0;
        vs_err  = 0;
        hs_fall.delete();
        hs_rise.delete();
        vs_fall.delete();
        vs_rise.delete();
        repeat (ncyc) begin
            tick();
            k++;
            if (forced) begin
                release dut.u_sig_gen.vc_q;
                forced = 1'b0;
            end
            p   = (k - 1) / 2;
            x   = p % 800;
            y   = (y_base + p / 800) % 525;
            vis = (x < 640) && (y < 480);
            ec  = (vis && ((((x >> 4) ^ (y >> 4)) & 1) != 0)) ? 8'hAA : 8'h00;
            eh  = !((x >= 656) && (x <= 751));
            ev  = !((y >= 490) && (y <= 491));
            if (colour !== ec) col_err++;
            if (hs !== eh) hs_err++;
            if (vs !== ev) vs_err++;
            if (prev_hs === 1'b1 && hs === 1'b0) hs_fall.push_back(k);
            if (prev_hs === 1'b0 && hs === 1'b1) hs_rise.push_back(k);
            if (prev_vs === 1'b1 && vs === 1'b0) vs_fall.push_back(k);
            if (prev_vs === 1'b0 && vs === 1'b1) vs_rise.push_back(k);
            prev_hs = hs;
            prev_vs = vs;
            foreach (vecs[i]) begin
                if (vecs[i].phase == cur_phase && vecs[i].cyc == k) begin
                    check($sformatf("vec%0d ph%0d k%0d colour", i, cur_phase, k), 32'(colour), 32'(vecs[i].colour));
                    check($sformatf("vec%0d ph%0d k%0d hs", i, cur_phase, k), 32'(hs), 32'(vecs[i].hs));
                    check($sformatf("vec%0d ph%0d k%0d vs", i, cur_phase, k), 32'(vs), 32'(vecs[i].vs));
                end
            end
        end
        check($sformatf("ph%0d colour model errors", cur_phase), col_err, 0);
        check($sformatf("ph%0d hs model errors", cur_phase), hs_err, 0);
        check($sformatf("ph%0d vs model errors", cur_phase), vs_err, 0);
    endtask

    initial begin
        // phase 0: frame from reset, line 0 onwards
        add(0,   0,  0, 8'h00, 1'b1, 1'b1);
        add(0,  15,  0, 8'h00, 1'b1, 1'b1);
        add(0,  16,  0, 8'hAA, 1'b1, 1'b1);
        add(0,  32,  0, 8'h00, 1'b1, 1'b1);
        add(0, 639,  0, 8'hAA, 1'b1, 1'b1);
        add(0, 640,  0, 8'h00, 1'b1, 1'b1);
        add(0, 655,  0, 8'h00, 1'b1, 1'b1);
        add(0, 656,  0, 8'h00, 1'b0, 1'b1);
        add(0, 751,  0, 8'h00, 1'b0, 1'b1);
        add(0, 752,  0, 8'h00, 1'b1, 1'b1);
        add(0, 799,  0, 8'h00, 1'b1, 1'b1);
        add(0,   0,  1, 8'h00, 1'b1, 1'b1);
        add(0,   0, 16, 8'hAA, 1'b1, 1'b1);
        add(0,  16, 16, 8'h00, 1'b1, 1'b1);
        // phase 1: starts at line 489
        add(1,   0,  0, 8'h00, 1'b1, 1'b1);
        add(1,   0,  1, 8'h00, 1'b1, 1'b0);
        add(1,   0,  3, 8'h00, 1'b1, 1'b1);
        // phase 2: starts at line 479
        add(2,   0,  0, 8'hAA, 1'b1, 1'b1);
        add(2, 639,  0, 8'h00, 1'b1, 1'b1);
        add(2, 640,  0, 8'h00, 1'b1, 1'b1);
        add(2,   0,  1, 8'h00, 1'b1, 1'b1);
        // phase 3: starts at line 524, wraps to line 0
        add(3,  16,  0, 8'h00, 1'b1, 1'b1);
        add(3, 799,  0, 8'h00, 1'b1, 1'b1);
        add(3,   0,  1, 8'h00, 1'b1, 1'b1);
        add(3,  16,  1, 8'hAA, 1'b1, 1'b1);
        // phase 4: line 300 before mid-frame reset; phase 5: after it
        add(4,  20,  0, 8'hAA, 1'b1, 1'b1);
        add(5,   0,  0, 8'h00, 1'b1, 1'b1);
        add(5,  16,  0, 8'hAA, 1'b1, 1'b1);

        do_reset(2);
        check("reset colour", 32'(colour), 32'h00);
        check("reset hs", 32'(hs), 32'h1);
        check("reset vs", 32'(vs), 32'h1);

        start(0, 0);
        run(27300);
        check("first hs fall", hs_fall.size() > 0 ? hs_fall[0] : -1, 1313);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("hs period %0d", i),
                  hs_fall.size() > i ? hs_fall[i] - hs_fall[i-1] : -1, 1600);
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("hs low width %0d", i),
                  (hs_rise.size() > i && hs_fall.size() > i) ? hs_rise[i] - hs_fall[i] : -1, 192);
        end

        do_reset(2);
        start(1, 489);
        run(5000);
        check("vs fall at line 490 start", vs_fall.size() > 0 ? vs_fall[0] : -1, 1601);
        check("vs low width",
              (vs_rise.size() > 0 && vs_fall.size() > 0) ? vs_rise[0] - vs_fall[0] : -1, 3200);

        do_reset(2);
        start(2, 479);
        run(1700);

        do_reset(2);
        start(3, 524);
        run(1700);

        do_reset(2);
        start(4, 300);
        run(42);
        do_reset(1);
        check("mid reset colour", 32'(colour), 32'h00);
        check("mid reset hs", 32'(hs), 32'h1);
        check("mid reset vs", 32'(vs), 32'h1);
        start(5, 0);
        run(1500);
        check("hs fall after mid reset", hs_fall.size() > 0 ? hs_fall[0] : -1, 1313);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
